// File: rtl/mod_alu_seq.sv
// Sequential modular ALU over GF(P): ADD, SUB, MUL and MAC behind valid/ready.
// The multiply is bit-serial and interleaved, MSB first, one operand bit per cycle.
// Every intermediate value is WIDTH+1 bits wide, so a modulus close to 2^WIDTH cannot overflow.
module mod_alu_seq #(
  parameter int unsigned      WIDTH = 32,
  parameter logic [WIDTH-1:0] P     = WIDTH'(37)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic             clr_acc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             err
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MAC = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             mac_q;
  logic             clr_q;

  logic [WIDTH:0]   dbl_c;
  logic [WIDTH-1:0] t_next_c;
  logic [WIDTH-1:0] acc_base_c;
  logic [WIDTH-1:0] mac_sum_c;
  logic             range_err_c;

  // (x + y) mod P for x, y < P
  function automatic logic [WIDTH-1:0] add_mod(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    logic [WIDTH:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return WIDTH'(s);
  endfunction

  // (x - y) mod P for x, y < P
  function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    logic [WIDTH:0] d;
    if (x >= y) d = {1'b0, x} - {1'b0, y};
    else        d = {1'b0, x} + {1'b0, P} - {1'b0, y};
    return WIDTH'(d);
  endfunction

  // One interleaved multiply step: t = 2t mod P, then add a when the current b bit is set
  always_comb begin
    dbl_c = {t, 1'b0};
    if (dbl_c >= {1'b0, P}) dbl_c = dbl_c - {1'b0, P};
    t_next_c = add_mod(WIDTH'(dbl_c), b_q[WIDTH-1] ? a_q : '0);
  end

  // MAC folds the final product into the accumulator, or into zero when clr_acc was set
  always_comb begin
    acc_base_c  = clr_q ? '0 : acc;
    mac_sum_c   = add_mod(acc_base_c, t_next_c);
    range_err_c = (a >= P) || (b >= P);
  end

  // Control FSM, operand capture, multiply datapath and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      r         <= '0;
      err       <= 1'b0;
      acc       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      t         <= '0;
      cnt       <= '0;
      mac_q     <= 1'b0;
      clr_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (range_err_c) begin
              r         <= '0;
              err       <= 1'b1;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end else begin
              err <= 1'b0;
              case (op)
                OP_ADD: begin
                  r         <= add_mod(a, b);
                  out_valid <= 1'b1;
                  state     <= S_DONE;
                end
                OP_SUB: begin
                  r         <= sub_mod(a, b);
                  out_valid <= 1'b1;
                  state     <= S_DONE;
                end
                default: begin
                  a_q   <= a;
                  b_q   <= b;
                  t     <= '0;
                  cnt   <= '0;
                  mac_q <= (op == OP_MAC);
                  clr_q <= clr_acc;
                  state <= S_MULT;
                end
              endcase
            end
          end
        end
        S_MULT: begin
          t   <= t_next_c;
          b_q <= b_q << 1;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            out_valid <= 1'b1;
            state     <= S_DONE;
            if (mac_q) begin
              r   <= mac_sum_c;
              acc <= mac_sum_c;
            end else begin
              r <= t_next_c;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
